// File: rtl/wb_mem_nport.sv
// N-port Wishbone-classic slave memory sharing one word array.
// Each port runs a small request FSM with programmable wait states; a
// round-robin arbiter admits one array access per cycle.
module wb_mem_nport #(
    parameter int unsigned NPORTS     = 2,
    parameter int unsigned AW         = 30,
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH_LOG2 = 14,
    parameter int unsigned BASE_WORD  = 0,
    parameter int unsigned WSW        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORTS*WSW-1:0]  ws,
    input  logic [NPORTS-1:0]      wb_cyc,
    input  logic [NPORTS-1:0]      wb_stb,
    input  logic [NPORTS-1:0]      wb_we,
    input  logic [NPORTS*AW-1:0]   wb_adr,
    input  logic [NPORTS*DW/8-1:0] wb_sel,
    input  logic [NPORTS*DW-1:0]   wb_dat_w,
    output logic [NPORTS*DW-1:0]   wb_dat_r,
    output logic [NPORTS-1:0]      wb_ack,
    output logic [NPORTS-1:0]      wb_err
);

    localparam int unsigned SW    = DW / 8;
    localparam int unsigned PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_RESP
    } state_t;

    state_t                state   [NPORTS];
    logic [AW-1:0]         adr_q   [NPORTS];
    logic                  we_q    [NPORTS];
    logic [SW-1:0]         sel_q   [NPORTS];
    logic [DW-1:0]         dat_q   [NPORTS];
    logic [WSW-1:0]        cnt_q   [NPORTS];
    logic [DEPTH_LOG2-1:0] idx_c   [NPORTS];
    logic [NPORTS-1:0]     oor_c;
    logic [NPORTS-1:0]     req_c;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         cand_c;
    logic [PW-1:0]         gnt_c;
    logic                  gnt_vld_c;

    logic [DW-1:0]         mem [DEPTH];

    // Address decode of each port's latched request: array index and range check
    always_comb begin
        for (int p = 0; p < int'(NPORTS); p++) begin
            idx_c[p] = DEPTH_LOG2'(adr_q[p] - AW'(BASE_WORD));
            oor_c[p] = (64'(adr_q[p]) < 64'(BASE_WORD)) ||
                       ((64'(adr_q[p]) - 64'(BASE_WORD)) >= (64'(1) << DEPTH_LOG2));
            req_c[p] = (state[p] == S_REQ) && wb_cyc[p];
        end
    end

    // Round-robin search starting at rr_ptr, wrapping after the last port
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_c     = '0;
        cand_c    = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            cand_c = PW'((32'(rr_ptr) + k) % NPORTS);
            if (!gnt_vld_c && req_c[cand_c]) begin
                gnt_vld_c = 1'b1;
                gnt_c     = cand_c;
            end
        end
    end

    // Byte-lane write of the granted in-range request; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && gnt_vld_c && we_q[gnt_c] && !oor_c[gnt_c]) begin
            for (int b = 0; b < int'(SW); b++) begin
                if (sel_q[gnt_c][b]) begin
                    mem[idx_c[gnt_c]][8*b +: 8] <= dat_q[gnt_c][8*b +: 8];
                end
            end
        end
    end

    // Per-port request FSMs, arbiter pointer and registered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            wb_ack   <= '0;
            wb_err   <= '0;
            wb_dat_r <= '0;
            for (int p = 0; p < int'(NPORTS); p++) begin
                state[p] <= S_IDLE;
                adr_q[p] <= '0;
                we_q[p]  <= 1'b0;
                sel_q[p] <= '0;
                dat_q[p] <= '0;
                cnt_q[p] <= '0;
            end
        end else begin
            wb_ack <= '0;
            wb_err <= '0;
            if (gnt_vld_c) begin
                rr_ptr <= PW'((32'(gnt_c) + 32'd1) % NPORTS);
            end
            for (int p = 0; p < int'(NPORTS); p++) begin
                case (state[p])
                    S_IDLE: begin
                        if (wb_cyc[p] && wb_stb[p]) begin
                            adr_q[p] <= wb_adr[p*AW +: AW];
                            we_q[p]  <= wb_we[p];
                            sel_q[p] <= wb_sel[p*SW +: SW];
                            dat_q[p] <= wb_dat_w[p*DW +: DW];
                            cnt_q[p] <= ws[p*WSW +: WSW];
                            state[p] <= (ws[p*WSW +: WSW] != '0) ? S_WAIT : S_REQ;
                        end
                    end
                    S_WAIT: begin
                        if (!wb_cyc[p]) begin
                            state[p] <= S_IDLE;
                        end else begin
                            cnt_q[p] <= cnt_q[p] - WSW'(1);
                            if (cnt_q[p] == WSW'(1)) begin
                                state[p] <= S_REQ;
                            end
                        end
                    end
                    S_REQ: begin
                        if (!wb_cyc[p]) begin
                            state[p] <= S_IDLE;
                        end else if (gnt_vld_c && (gnt_c == PW'(p))) begin
                            state[p]  <= S_RESP;
                            wb_ack[p] <= !oor_c[p];
                            wb_err[p] <= oor_c[p];
                            if (oor_c[p]) begin
                                wb_dat_r[p*DW +: DW] <= '0;
                            end else if (!we_q[p]) begin
                                wb_dat_r[p*DW +: DW] <= mem[idx_c[p]];
                            end
                        end
                    end
                    S_RESP: begin
                        // response pulse is already on the outputs; stb is not re-sampled here
                        state[p] <= S_IDLE;
                    end
                    default: begin
                        state[p] <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
